// File: rtl/multi_player_turn_fsm.sv
// Turn-sequencing controller for multi-player board games.
// Grants one player per turn, accepts one move per turn, then waits one
// cycle for the board evaluator before passing the turn on or ending the
// game as a win or a draw. All outputs are registered.
// Optional feature macro: TURN_TIMEOUT_EN (per-turn forfeit timer).
module multi_player_turn_fsm #(
    parameter int NUM_PLAYERS    = 2,
    parameter int PID_W          = 3,
    parameter int NUM_CELLS      = 9,
    parameter int CNT_W          = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_play,
    input  logic                   i_move_valid,
    input  logic                   i_win,
    input  logic                   i_no_space,
    input  logic                   i_new_game,
    output logic [NUM_PLAYERS-1:0] o_player_play,
    output logic [PID_W-1:0]       o_turn_id,
    output logic                   o_move_ack,
    output logic [CNT_W-1:0]       o_move_count,
    output logic                   o_game_over,
    output logic [PID_W-1:0]       o_winner_id,
    output logic                   o_draw,
    output logic                   o_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } t_state;

    // Illegal configurations show up as a named scope in the elaborated tree.
    if ((NUM_PLAYERS < 2) || (NUM_PLAYERS > 8) || ((2 ** PID_W) < NUM_PLAYERS) ||
        ((2 ** CNT_W) <= NUM_CELLS) || (TIMEOUT_CYCLES < 2)) begin : g_bad_config
    end

    t_state                 r_state, w_state_next;
    logic [NUM_PLAYERS-1:0] r_player_play, w_player_play_next;
    logic [PID_W-1:0]       r_turn_id, w_turn_id_next;
    logic                   r_move_ack, w_move_ack_next;
    logic [CNT_W-1:0]       r_move_count, w_move_count_next;
    logic                   r_game_over, w_game_over_next;
    logic [PID_W-1:0]       r_winner_id, w_winner_id_next;
    logic                   r_draw, w_draw_next;
    logic                   r_timeout, w_timeout_next;
    logic [PID_W-1:0]       w_turn_inc;
    logic [CNT_W-1:0]       w_count_inc;

`ifdef TURN_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    logic [TMR_W-1:0] r_timer, w_timer_next;
`endif

    function automatic logic [NUM_PLAYERS-1:0] f_onehot(input logic [PID_W-1:0] id);
        f_onehot = NUM_PLAYERS'(1) << id;
    endfunction

    // Next player index with wrap, and saturating move-count increment.
    assign w_turn_inc  = (r_turn_id == PID_W'(NUM_PLAYERS - 1)) ? '0 : r_turn_id + PID_W'(1);
    assign w_count_inc = (r_move_count == CNT_W'(NUM_CELLS)) ? r_move_count
                                                              : r_move_count + CNT_W'(1);

    // State and registered outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_player_play <= '0;
            r_turn_id     <= '0;
            r_move_ack    <= 1'b0;
            r_move_count  <= '0;
            r_game_over   <= 1'b0;
            r_winner_id   <= '0;
            r_draw        <= 1'b0;
            r_timeout     <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            r_timer       <= TMR_LOAD;
`endif
        end else begin
            r_state       <= w_state_next;
            r_player_play <= w_player_play_next;
            r_turn_id     <= w_turn_id_next;
            r_move_ack    <= w_move_ack_next;
            r_move_count  <= w_move_count_next;
            r_game_over   <= w_game_over_next;
            r_winner_id   <= w_winner_id_next;
            r_draw        <= w_draw_next;
            r_timeout     <= w_timeout_next;
`ifdef TURN_TIMEOUT_EN
            r_timer       <= w_timer_next;
`endif
        end
    end

    // Next-state and next-output decode; new_game overrides everything.
    always_comb begin
        w_state_next       = r_state;
        w_player_play_next = '0;
        w_turn_id_next     = r_turn_id;
        w_move_ack_next    = 1'b0;
        w_move_count_next  = r_move_count;
        w_game_over_next   = 1'b0;
        w_winner_id_next   = r_winner_id;
        w_draw_next        = r_draw;
        w_timeout_next     = 1'b0;
`ifdef TURN_TIMEOUT_EN
        // Timer reloads on every cycle outside TURN, so each TURN entry starts full.
        w_timer_next       = TMR_LOAD;
`endif
        if (i_new_game) begin
            w_state_next      = IDLE;
            w_turn_id_next    = '0;
            w_move_count_next = '0;
            w_winner_id_next  = '0;
            w_draw_next       = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_play) begin
                        w_state_next       = TURN;
                        w_turn_id_next     = '0;
                        w_move_count_next  = '0;
                        w_winner_id_next   = '0;
                        w_draw_next        = 1'b0;
                        w_player_play_next = f_onehot('0);
                    end
                end
                TURN: begin
                    if (i_move_valid) begin
                        w_state_next      = CHECK;
                        w_move_ack_next   = 1'b1;
                        w_move_count_next = w_count_inc;
                    end
`ifdef TURN_TIMEOUT_EN
                    else if (r_timer == '0) begin
                        // Forfeit: hand the turn on without visiting CHECK.
                        w_timeout_next     = 1'b1;
                        w_turn_id_next     = w_turn_inc;
                        w_player_play_next = f_onehot(w_turn_inc);
                    end else begin
                        w_timer_next       = r_timer - TMR_W'(1);
                        w_player_play_next = f_onehot(r_turn_id);
                    end
`else
                    else begin
                        w_player_play_next = f_onehot(r_turn_id);
                    end
`endif
                end
                CHECK: begin
                    if (i_win) begin
                        w_state_next     = DONE;
                        w_game_over_next = 1'b1;
                        w_winner_id_next = r_turn_id;
                        w_draw_next      = 1'b0;
                    end else if (i_no_space || (r_move_count == CNT_W'(NUM_CELLS))) begin
                        w_state_next     = DONE;
                        w_game_over_next = 1'b1;
                        w_draw_next      = 1'b1;
                    end else begin
                        w_state_next       = TURN;
                        w_turn_id_next     = w_turn_inc;
                        w_player_play_next = f_onehot(w_turn_inc);
                    end
                end
                DONE: begin
                    w_game_over_next = 1'b1;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    assign o_player_play = r_player_play;
    assign o_turn_id     = r_turn_id;
    assign o_move_ack    = r_move_ack;
    assign o_move_count  = r_move_count;
    assign o_game_over   = r_game_over;
    assign o_winner_id   = r_winner_id;
    assign o_draw        = r_draw;
    assign o_timeout     = r_timeout;

endmodule

// File: doc/multi_player_turn_fsm.md
Name: multi_player_turn_fsm

Overview:
- Parametrised turn-sequencing controller for board games: NUM_PLAYERS players (2..8) over an N-cell board.
- Sits between the player input decode and the board/win evaluator.
- Grants exactly one player per turn and accepts one move per turn.
- Waits one cycle for evaluator results, then either passes the turn on or ends the game as a win or a draw.
- All outputs are registered. Adds a move counter, an abort path, winner/draw reporting and an optional turn timeout.

Parameters:
- NUM_PLAYERS, 2: number of players, legal range 2..8.
- PID_W, 3: player-id width. Must satisfy 2**PID_W >= NUM_PLAYERS.
- NUM_CELLS, 9: board cells. The game is a draw when this many moves are accepted with no win.
- CNT_W, 4: move-counter width. Must satisfy 2**CNT_W > NUM_CELLS.
- TIMEOUT_CYCLES, 1000: cycles allowed per turn. Used only when TURN_TIMEOUT_EN is defined. Must be >= 2.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; forces every register to its reset value.
- play  in  1  start request; sampled in IDLE only.
- move_valid  in  1  current player submits a move; sampled in TURN only.
- win  in  1  evaluator flag: last move completed a line; sampled in CHECK only.
- no_space  in  1  evaluator flag: board full; sampled in CHECK only.
- new_game  in  1  synchronous abort/restart request, any state.
- player_play  out  NUM_PLAYERS  one-hot grant; bit i = player i may move.
- turn_id  out  PID_W  index of the current player.
- move_ack  out  1  one-cycle pulse when a move is accepted.
- move_count  out  CNT_W  number of accepted moves.
- game_over  out  1  high while in DONE.
- winner_id  out  PID_W  player who won; valid when game_over=1 and draw=0.
- draw  out  1  game ended with no winner.
- timeout  out  1  one-cycle pulse when a turn is forfeited.

Behaviour:
- Reset values: all outputs are 0; state=IDLE.
- State encoding: IDLE=0, TURN=1, CHECK=2, DONE=3.
- new_game priority: new_game=1 in any state forces IDLE on the next edge and clears move_count, turn_id, winner_id, draw and game_over. It overrides every other input in the same cycle.
- IDLE:
  - player_play=0.
  - play=1 -> TURN, with turn_id=0 and move_count=0.
  - Otherwise stay in IDLE.
- TURN:
  - player_play = one-hot of turn_id, registered and updated on the same edge as the state.
  - move_valid=1 -> CHECK, move_ack=1 for exactly one cycle (the first CHECK cycle), move_count+1.
  - move_count saturates at NUM_CELLS.
- CHECK (exactly one cycle):
  - player_play=0.
  - win=1 -> DONE, winner_id=turn_id, draw=0.
  - Else if no_space=1 or move_count==NUM_CELLS -> DONE, draw=1.
  - Else -> TURN with turn_id+1. After NUM_PLAYERS-1, turn_id wraps to 0.
  - win and no_space both high: win takes priority and draw=0.
- DONE:
  - game_over=1, player_play=0.
  - winner_id and draw hold their values.
  - Stay in DONE until new_game or reset.
  - play and move_valid are ignored.
- Inputs outside their sampling state are ignored. move_valid held high in TURN produces exactly one move per TURN entry.
- Latency:
  - move_valid to move_ack: 1 cycle.
  - move_valid to next player's grant: 2 cycles.
  - move_valid to game_over: 2 cycles.
- Reset asserted mid-game clears state and outputs immediately, without waiting for a clock edge.

Optional Feature:
- Macro name: TURN_TIMEOUT_EN.
- Defined:
  - Per-turn down-counter loads TIMEOUT_CYCLES-1 on every TURN entry and decrements each TURN cycle.
  - Counter at 0 with move_valid=0 -> timeout pulse for 1 cycle; turn_id advances (with wrap) and TURN is re-entered with a reloaded counter.
  - A forfeit does not change move_count and does not visit CHECK.
  - move_valid in the expiry cycle: the move is accepted and no timeout is raised.
- Not defined: no timer logic; timeout is tied to 0. The port is always present.

Test Plan:
- Two-player win: reset, play=1, then P0 move, P1 move, P0 move with win=1 in CHECK. Required: turn_id goes 0,1,0; game_over=1 two cycles after the third move_valid; winner_id=0; draw=0; move_count=3.
- Draw, NUM_CELLS=9, NUM_PLAYERS=2: 9 moves with win=0 and no_space=0. Required: after the 9th move, draw=1 and game_over=1 from the move_count==9 rule alone.
- Wrap, NUM_PLAYERS=3: 4 non-winning moves. Required: player_play sequence 001,010,100,001; in CHECK cycles player_play=000.
- Priority and abort: win=1 and no_space=1 in CHECK -> winner_id=turn_id, draw=0. Then new_game=1 in DONE -> IDLE next cycle with all outputs 0. Also new_game in TURN -> IDLE.
- Reset mid-game: assert reset between clock edges during TURN. Required: player_play=0 and move_count=0 immediately, before the next edge.
- TURN_TIMEOUT_EN, TIMEOUT_CYCLES=4: no move for 4 TURN cycles -> timeout pulses, turn_id 0->1, move_count unchanged. Repeat with move_valid in the expiry cycle -> move_ack=1, timeout=0.
